// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment width, blank code, hex glyph table, one-hot helper.
// Pure constants and functions; no latency, no flow control.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Bit 0 = segment a ... bit 6 = segment g, active-high.
    localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to seven-segment glyph lookup, purely combinational.
// Zero latency; no flow control.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver, double-buffered, values committed at frame boundaries.
// Outputs registered (1 cycle after index); optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         shadow_val;
    logic [VW-1:0]         disp_val;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic                  tick;
    logic                  last_digit;
    logic                  boundary;
    logic [3:0]            cur_nibble;
    logic [SEG_W-1:0]      cur_glyph;
    logic                  cur_en;
    logic                  cur_blank;
    logic [7:0]            sel_wide;
    logic [NUM_DIGITS-1:0] sel;

    assign tick       = (presc == PW'(SCAN_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign boundary   = tick && last_digit;

    assign cur_nibble = disp_val[{idx, 2'b00} +: 4];
    assign cur_en     = digit_en[idx];
    assign sel_wide   = onehot8(3'(idx));
    assign sel        = sel_wide[NUM_DIGITS-1:0];

    seg7_hex_dec u_hex_dec (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msnz;

    // Digit 0 is never above msnz, so an all-zero value still shows "0".
    always_comb begin
        msnz = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_val[4*i +: 4] != 4'h0) begin
                msnz = IW'(i);
            end
        end
        cur_blank = (idx > msnz);
    end
`else
    assign cur_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= last_digit ? '0 : idx + 1'b1;
            end
            frame_done <= boundary;

            // A load on the boundary bypasses the shadow so it shows in the very next frame.
            if (boundary) begin
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                    pending  <= 1'b0;
                end else if (pending) begin
                    disp_val <= shadow_val;
                    disp_dp  <= shadow_dp;
                    pending  <= 1'b0;
                end
            end else if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end

            an  <= cur_en ? sel : '0;
            seg <= (cur_en && !cur_blank) ? cur_glyph : SEG_BLANK;
            dp  <= disp_dp[idx] & cur_en;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic against a time-based reference model.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int FRAME = N * DIV;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [15:0]  value = '0;
    logic [3:0]   dp_in = '0;
    logic [3:0]   digit_en = 4'hF;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   an;
    logic         frame_done;
    logic         pending;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_vec = 0;
    int n_err = 0;

    // Reference state: cycles since reset release, displayed and buffered values.
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_shadow_dp = '0;
    logic        m_pending = 1'b0;

    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic run_cycle(input logic r, input logic ld, input logic [15:0] v,
                             input logic [3:0] d, input logic [3:0] en);
        int   dig;
        bit   bnd;
        bit   blank;
        logic [3:0] nib;
        @(negedge clk);
        rst_n = r; load = ld; value = v; dp_in = d; digit_en = en;
        if (!r) begin
            m_t = 0; m_disp = '0; m_disp_dp = '0; m_shadow = '0; m_shadow_dp = '0;
            m_pending = 1'b0;
            e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            dig = (m_t / DIV) % N;
            bnd = (m_t % FRAME) == FRAME - 1;
            nib = 4'((m_disp >> (4 * dig)) & 16'hF);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank = (dig != 0) && ((m_disp >> (4 * dig)) == 16'h0);
`else
            blank = 1'b0;
`endif
            e_an  = en[dig] ? 4'(1 << dig) : 4'h0;
            e_seg = (en[dig] && !blank) ? glyph[nib] : 7'h00;
            e_dp  = m_disp_dp[dig] & en[dig];
            e_fd  = bnd;
            if (bnd) begin
                if (ld) begin
                    m_disp = v; m_disp_dp = d; m_pending = 1'b0;
                end else if (m_pending) begin
                    m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pending = 1'b0;
                end
            end else if (ld) begin
                m_shadow = v; m_shadow_dp = d; m_pending = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("pending", 32'(pending), 32'(m_pending));
    endtask

    task automatic idle(input int n, input logic [3:0] en);
        for (int k = 0; k < n; k++) run_cycle(1'b1, 1'b0, 16'h0, 4'h0, en);
    endtask

    task automatic align_to_boundary(input logic [3:0] en);
        for (int k = 0; k < FRAME && (m_t % FRAME) != FRAME - 1; k++) idle(1, en);
    endtask

    initial begin
        logic       r;
        logic       ld;
        logic [3:0] en;

        // Reset hold, then first digit of the zero value.
        for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'hF);
        run_cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
        check("rel_an", 32'(an), 32'h1);
        check("rel_seg", 32'(seg), 32'h3F);

        // Mid-frame load waits for the boundary.
        idle(4, 4'hF);
        run_cycle(1'b1, 1'b1, 16'h1A9F, 4'b0100, 4'hF);
        check("load_pend", 32'(pending), 32'h1);
        idle(2 * FRAME, 4'hF);

        // Two loads in one frame: last wins.
        idle(2, 4'hF);
        run_cycle(1'b1, 1'b1, 16'h1111, 4'h0, 4'hF);
        idle(1, 4'hF);
        run_cycle(1'b1, 1'b1, 16'h2222, 4'h0, 4'hF);
        idle(2 * FRAME, 4'hF);

        // Load on the boundary tick itself.
        align_to_boundary(4'hF);
        run_cycle(1'b1, 1'b1, 16'h3C5D, 4'b1001, 4'hF);
        check("bnd_pend", 32'(pending), 32'h0);
        idle(FRAME + 2, 4'hF);

        // Partially enabled digits.
        run_cycle(1'b1, 1'b1, 16'h8888, 4'hF, 4'b1010);
        idle(2 * FRAME, 4'b1010);

        // Reset mid-frame discards the pending shadow.
        idle(3, 4'hF);
        run_cycle(1'b1, 1'b1, 16'hBEEF, 4'hF, 4'hF);
        run_cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'hF);
        check("rst_pend", 32'(pending), 32'h0);
        idle(2 * FRAME, 4'hF);

        // Leading-zero patterns (blanked only when the feature is compiled in).
        run_cycle(1'b1, 1'b1, 16'h0040, 4'h0, 4'hF);
        idle(2 * FRAME, 4'hF);
        run_cycle(1'b1, 1'b1, 16'h0000, 4'h0, 4'hF);
        idle(2 * FRAME, 4'hF);
        run_cycle(1'b1, 1'b1, 16'h0305, 4'b0010, 4'hF);
        idle(2 * FRAME, 4'hF);

        // Random traffic.
        en = 4'hF;
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 299) != 0);
            ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) en = 4'($urandom);
            run_cycle(r, ld, 16'($urandom), 4'($urandom), en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit hex decoder. It time-multiplexes a packed hex value onto one shared active-high segment bus with one select line per digit. New values are double-buffered and committed only at frame boundaries, so the display never tears. It sits between user logic (counters, FSM status) and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)

Ports:
clk  input  1  system clock, single domain
rst_n  input  1  synchronous reset, active-low
load  input  1  capture value/dp_in into shadow register this cycle
value  input  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 = least significant
dp_in  input  NUM_DIGITS  per-digit decimal point request
digit_en  input  NUM_DIGITS  per-digit enable; 0 blanks that digit (sampled live)
seg  output  7  segments, seg[0]=a .. seg[6]=g, active-high
dp  output  1  decimal point of current digit, active-high
an  output  NUM_DIGITS  one-hot digit select, active-high
frame_done  output  1  one-cycle pulse at each frame boundary
pending  output  1  shadow holds a value not yet displayed

Behaviour:
- Clock/reset: one clock clk; reset rst_n is synchronous, active-low; all state updates on rising clk only.
- Reset values: prescaler=0, digit index=0, shadow/display value and dp=0, pending=0, seg=0, dp=0, an=0, frame_done=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The cycle it holds SCAN_DIV-1 is a slot tick; index advances, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = slot tick while index==NUM_DIGITS-1. frame_done=1 in the following cycle only.
- load=1 (not at a boundary): shadow <= value/dp_in, pending <= 1. Repeated loads overwrite the shadow; the last one wins.
- At a boundary: if load=1 in the same cycle, display <= value/dp_in directly and pending <= 0. Otherwise, if pending=1, display <= shadow and pending <= 0. Otherwise display is unchanged.
- Outputs are registered and reflect the index one cycle later. an = one-hot(index) if digit_en[index], else 0. seg = glyph(display nibble[index]) if enabled, else 0. dp = display_dp[index] & digit_en[index].
- Glyphs, hex seg values 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Reset mid-frame: returns to reset state the next cycle and discards pending data. The first frame after reset starts at digit 0.
- NUM_DIGITS=1: every slot tick is a frame boundary.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: zero nibbles above the most significant nonzero nibble of the display register are blanked (seg=0, an still asserted, dp unaffected). Digit 0 is never blanked, so value 0 shows "0".
- Undefined: every enabled digit shows its glyph, including leading zeros.

Decomposition:
- Package seg7_pkg: SEG_W=7, SEG_BLANK=7'h00, 16-entry glyph constant table, one-hot helper function.
- Sub-module seg7_hex_dec: pure combinational 4-bit nibble -> 7-bit glyph using the package table. The driver instantiates one and feeds it the muxed nibble.
- The driver owns the prescaler, index, shadow/display registers and output registers.

Test Plan:
Bench uses NUM_DIGITS=4, SCAN_DIV=4.
1. Reset hold 3 cycles, release -> seg=00, an=0, pending=0. Next cycle an=0001, seg=3F (digit 0 of zero value).
2. load with value=16'h1A9F, dp_in=4'b0100 mid-frame -> pending=1 and display unchanged until boundary. Then frame_done pulses, pending=0, and the next frame shows an=0001 seg=71, an=0010 seg=6F, an=0100 seg=77 dp=1, an=1000 seg=06.
3. Two loads in one frame (16'h1111 then 16'h2222) -> next frame shows only 5B on all digits. A load coinciding with the boundary tick -> displayed in the immediately following frame, with pending staying 0.
4. digit_en=4'b1010 with value 16'h8888 -> an=0000 and seg=00 during slots 0 and 2; an=0010/1000 with seg=7F during slots 1 and 3.
5. rst_n low for one cycle mid-frame with pending=1 -> all outputs and pending return to reset values. The index restarts at 0 and the old shadow is never displayed.
6. With SEG7_LEADING_ZERO_BLANK_EN: value 16'h0040 -> digits 3,2 seg=00; digit 1 seg=66; digit 0 seg=3F. Value 16'h0000 -> only digit 0 shows 3F.
